// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator datapath.
package product_acc_pkg;

    localparam int PROD_W = 16;

    typedef enum logic {
        ACCUM,
        DONE
    } state_e;

    // Clamp limits for a signed accumulator of accW bits, computed wide enough for accW up to 32.
    function automatic logic signed [32:0] satMax(input int accW);
        return (33'sd1 <<< (accW - 1)) - 33'sd1;
    endfunction

    function automatic logic signed [32:0] satMin(input int accW);
        return -(33'sd1 <<< (accW - 1));
    endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational signed add that clamps to the ACC_W range and flags overflow.
module sat_add
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] addend_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(satMax(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(satMin(ACC_W));

    logic [ACC_W:0] wide;

    // One extra bit is enough: both operands fit in ACC_W bits, so the sum fits in ACC_W+1.
    assign wide = {acc_i[ACC_W-1], acc_i} + {addend_i[ACC_W-1], addend_i};

    always_comb begin
        ovf_o = wide[ACC_W] ^ wide[ACC_W-1];
        sum_o = wide[ACC_W-1:0];
        if (ovf_o) begin
            sum_o = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Saturating group accumulator fed by the 8x8 multiplier; one registered result per group.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      product,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat,
    output logic [CNT_W-1:0] terms,
    output logic             len_err
);

    localparam logic [CNT_W-1:0] TERM_MAX = '1;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] terms_q;
    logic [CNT_W-1:0] terms_d;
    logic             sat_q;
    logic             lenErr_q;
    logic             ovf;
    logic             accept;
    logic [ACC_W-1:0] addend;

    assign prod_ready = (state_q == ACCUM) && !rst;
    assign accept     = prod_valid && prod_ready;
    assign addend     = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
    assign terms_d    = terms_q + 1'b1;

    sat_add #(
        .ACC_W(ACC_W)
    ) u_sat_add (
        .acc_i   (acc_q),
        .addend_i(addend),
        .sum_o   (acc_d),
        .ovf_o   (ovf)
    );

    // A group closes on last or when the counter is full; only the latter is a length error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            terms_q  <= '0;
            sat_q    <= 1'b0;
            lenErr_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        terms_q <= terms_d;
                        sat_q   <= sat_q | ovf;
                        if (last || (terms_d == TERM_MAX)) begin
                            state_q <= DONE;
                        end
                        if (!last && (terms_d == TERM_MAX)) begin
                            lenErr_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q  <= ACCUM;
                        acc_q    <= '0;
                        terms_q  <= '0;
                        sat_q    <= 1'b0;
                        lenErr_q <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign terms     = terms_q;
    assign sat       = sat_q;
    assign len_err   = lenErr_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (24/8, 18/8, 24/3) against an arithmetic model.
`timescale 1ns/1ps
module tb_product_accumulator;

    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
        longint      expAcc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic        pv[3];
    logic [15:0] prod[3];
    logic        lst[3];
    logic        ordy[3];
    logic        rdy[3];
    logic        ov[3];
    logic        satO[3];
    logic        lerr[3];
    logic [23:0] acc0;
    logic [17:0] acc1;
    logic [23:0] acc2;
    logic [7:0]  trm0;
    logic [7:0]  trm1;
    logic [2:0]  trm2;

    int vectors = 0;
    int miscompares = 0;

    longint mAcc[3];
    int     mTerms[3];
    bit     mSat[3];
    bit     mLen[3];
    int     accW[3]   = '{24, 18, 24};
    int     cntMax[3] = '{255, 255, 7};

    initial forever #5 clk = ~clk;

    product_accumulator #(.ACC_W(24), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .prod_valid(pv[0]), .prod_ready(rdy[0]), .product(prod[0]),
        .last(lst[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .acc_out(acc0),
        .sat(satO[0]), .terms(trm0), .len_err(lerr[0]));

    product_accumulator #(.ACC_W(18), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .prod_valid(pv[1]), .prod_ready(rdy[1]), .product(prod[1]),
        .last(lst[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .acc_out(acc1),
        .sat(satO[1]), .terms(trm1), .len_err(lerr[1]));

    product_accumulator #(.ACC_W(24), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .prod_valid(pv[2]), .prod_ready(rdy[2]), .product(prod[2]),
        .last(lst[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .acc_out(acc2),
        .sat(satO[2]), .terms(trm2), .len_err(lerr[2]));

    function automatic longint accOf(input int d);
        case (d)
            0:       return longint'($signed(acc0));
            1:       return longint'($signed(acc1));
            default: return longint'($signed(acc2));
        endcase
    endfunction

    function automatic longint termsOf(input int d);
        case (d)
            0:       return longint'(trm0);
            1:       return longint'(trm1);
            default: return longint'(trm2);
        endcase
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted term: inputs set after an edge, taken on the following edge.
    task automatic applyStimulus(input int d, input logic [15:0] p, input logic l);
        pv[d]   = 1'b1;
        prod[d] = p;
        lst[d]  = l;
        cyc();
        pv[d]   = 1'b0;
        lst[d]  = 1'b0;
    endtask

    task automatic modelClear(input int d);
        mAcc[d]   = 0;
        mTerms[d] = 0;
        mSat[d]   = 1'b0;
        mLen[d]   = 1'b0;
    endtask

    // Reference: exact sum clamped to the signed range after every term.
    task automatic modelAccept(input int d, input logic [15:0] p, input logic l, output bit done);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) << (accW[d] - 1)) - 1;
        lo = -(hi + 1);
        s  = mAcc[d] + longint'($signed(p));
        if (s > hi) begin
            s = hi;
            mSat[d] = 1'b1;
        end else if (s < lo) begin
            s = lo;
            mSat[d] = 1'b1;
        end
        mAcc[d] = s;
        mTerms[d]++;
        done = l || (mTerms[d] == cntMax[d]);
        if (!l && (mTerms[d] == cntMax[d])) mLen[d] = 1'b1;
    endtask

    task automatic checkGroup(input int d);
        checkOutput("model_out_valid", longint'(ov[d]), 1);
        checkOutput("model_acc", accOf(d), mAcc[d]);
        checkOutput("model_terms", termsOf(d), longint'(mTerms[d]));
        checkOutput("model_sat", longint'(satO[d]), longint'(mSat[d]));
        checkOutput("model_len_err", longint'(lerr[d]), longint'(mLen[d]));
    endtask

    task automatic handshake(input int d);
        ordy[d] = 1'b1;
        cyc();
        ordy[d] = 1'b0;
        checkOutput("hs_out_valid_low", longint'(ov[d]), 0);
        checkOutput("hs_prod_ready", longint'(rdy[d]), 1);
        checkOutput("hs_acc_cleared", accOf(d), 0);
    endtask

    initial begin
        vec_t tbl[6];
        bit   done;
        tbl[0] = '{16'h0001, 16'h0002, 3};
        tbl[1] = '{16'hFFFF, 16'hFFFF, -2};
        tbl[2] = '{16'h7FFF, 16'h8000, -1};
        tbl[3] = '{16'h3F01, 16'hC000, -255};
        tbl[4] = '{16'h8000, 16'h8000, -65536};
        tbl[5] = '{16'h7FFF, 16'h7FFF, 65534};

        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; prod[i] = '0; lst[i] = 1'b0; ordy[i] = 1'b0;
            modelClear(i);
        end

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        checkOutput("rst_prod_ready", longint'(rdy[0]), 0);
        checkOutput("rst_out_valid", longint'(ov[0]), 0);
        checkOutput("rst_acc", accOf(0), 0);
        checkOutput("rst_terms", termsOf(0), 0);
        checkOutput("rst_sat", longint'(satO[0]), 0);
        checkOutput("rst_len_err", longint'(lerr[0]), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_prod_ready", longint'(rdy[0]), 1);
        cyc();

        // Two-term table on the 24-bit instance
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, tbl[i].p0, 1'b0);
            applyStimulus(0, tbl[i].p1, 1'b1);
            checkOutput("tbl_out_valid", longint'(ov[0]), 1);
            checkOutput("tbl_acc", accOf(0), tbl[i].expAcc);
            checkOutput("tbl_terms", termsOf(0), 2);
            handshake(0);
        end

        // Reset mid-group discards the partial sum; rst also beats a pending accept
        applyStimulus(0, 16'h3F01, 1'b0);
        applyStimulus(0, 16'h3F01, 1'b0);
        rst = 1'b1;
        pv[0] = 1'b1;
        prod[0] = 16'h1234;
        #1;
        checkOutput("midrst_prod_ready", longint'(rdy[0]), 0);
        cyc();
        rst = 1'b0;
        pv[0] = 1'b0;
        checkOutput("midrst_out_valid", longint'(ov[0]), 0);
        checkOutput("midrst_acc", accOf(0), 0);
        checkOutput("midrst_terms", termsOf(0), 0);
        applyStimulus(0, 16'h0001, 1'b1);
        checkOutput("single_out_valid", longint'(ov[0]), 1);
        checkOutput("single_acc", accOf(0), 1);
        checkOutput("single_terms", termsOf(0), 1);
        handshake(0);

        // Three-term group with out_ready held high: one-cycle out_valid, 4-cycle period
        ordy[0] = 1'b1;
        applyStimulus(0, 16'h3F01, 1'b0);
        applyStimulus(0, 16'h4000, 1'b0);
        applyStimulus(0, 16'hC000, 1'b1);
        checkOutput("three_out_valid", longint'(ov[0]), 1);
        checkOutput("three_acc", accOf(0), 64'h3F01);
        checkOutput("three_terms", termsOf(0), 3);
        checkOutput("three_sat", longint'(satO[0]), 0);
        cyc();
        checkOutput("three_valid_one_cycle", longint'(ov[0]), 0);
        checkOutput("three_ready_for_next", longint'(rdy[0]), 1);
        ordy[0] = 1'b0;

        // Backpressure: result held, input ignored while out_ready is low
        applyStimulus(0, 16'h0055, 1'b0);
        applyStimulus(0, 16'h00AA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            pv[0] = 1'b1;
            prod[0] = 16'($urandom);
            lst[0] = 1'($urandom);
            checkOutput("bp_prod_ready", longint'(rdy[0]), 0);
            cyc();
            checkOutput("bp_acc_held", accOf(0), 64'hFF);
            checkOutput("bp_out_valid", longint'(ov[0]), 1);
        end
        pv[0] = 1'b0;
        lst[0] = 1'b0;
        handshake(0);

        // Positive saturation, ACC_W = 18
        for (int i = 0; i < 7; i++) applyStimulus(1, 16'h4000, 1'b0);
        checkOutput("sat7_acc", accOf(1), 114688);
        checkOutput("sat7_flag", longint'(satO[1]), 0);
        applyStimulus(1, 16'h4000, 1'b0);
        checkOutput("sat8_acc", accOf(1), 131071);
        checkOutput("sat8_flag", longint'(satO[1]), 1);
        applyStimulus(1, 16'h4000, 1'b0);
        applyStimulus(1, 16'hC000, 1'b1);
        checkOutput("satpos_out_valid", longint'(ov[1]), 1);
        checkOutput("satpos_acc", accOf(1), 114687);
        checkOutput("satpos_flag", longint'(satO[1]), 1);
        checkOutput("satpos_terms", termsOf(1), 10);
        handshake(1);
        checkOutput("satpos_flag_cleared", longint'(satO[1]), 0);

        // Negative clamp, ACC_W = 18
        for (int i = 0; i < 8; i++) applyStimulus(1, 16'h8001, 1'b0);
        applyStimulus(1, 16'h8001, 1'b1);
        checkOutput("satneg_acc", accOf(1), -131072);
        checkOutput("satneg_flag", longint'(satO[1]), 1);
        handshake(1);

        // Counter limit, CNT_W = 3
        for (int i = 0; i < 6; i++) applyStimulus(2, 16'h0001, 1'b0);
        checkOutput("cnt6_out_valid", longint'(ov[2]), 0);
        applyStimulus(2, 16'h0001, 1'b0);
        checkOutput("cnt7_out_valid", longint'(ov[2]), 1);
        checkOutput("cnt7_terms", termsOf(2), 7);
        checkOutput("cnt7_acc", accOf(2), 7);
        checkOutput("cnt7_len_err", longint'(lerr[2]), 1);
        handshake(2);
        checkOutput("cnt_len_err_cleared", longint'(lerr[2]), 0);
        for (int i = 0; i < 6; i++) applyStimulus(2, 16'h0001, 1'b0);
        applyStimulus(2, 16'h0001, 1'b1);
        checkOutput("cntlast_out_valid", longint'(ov[2]), 1);
        checkOutput("cntlast_len_err", longint'(lerr[2]), 0);
        handshake(2);

        // Randomized groups with idle gaps, garbage on idle inputs and variable backpressure
        for (int g = 0; g < 45; g++) begin
            int d;
            int n;
            d = g % 3;
            n = $urandom_range(1, 12);
            modelClear(d);
            done = 1'b0;
            for (int t = 0; t < n && !done; t++) begin
                logic [15:0] p;
                logic        l;
                int          idle;
                idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) begin
                    prod[d] = 16'($urandom);
                    lst[d]  = 1'($urandom);
                    cyc();
                end
                p = 16'($urandom);
                l = (t == n - 1);
                applyStimulus(d, p, l);
                modelAccept(d, p, l, done);
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) cyc();
            checkGroup(d);
            handshake(d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulate stage directly downstream of the 8x8 signed multiplier `Top`. It consumes the multiplier's 16-bit two's-complement products through a valid/ready handshake and sums each group of products, with group boundaries marked by `last`. It saturates the running sum to ACC_W bits and presents one registered result per group with a sticky saturation flag and a term count. It turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- ACC_W, 24: accumulator and result width in bits, signed; legal range 17..32.
- CNT_W, 8: term counter width; a group holds at most 2^CNT_W-1 terms.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- prod_valid  in  1  product present on `product`.
- prod_ready  out  1  block accepts a product this cycle.
- product  in  16  signed product from the multiplier (answer[15:0]).
- last  in  1  qualifies `product` as the final term of the group.
- out_valid  out  1  `acc_out`, `sat` and `terms` are valid.
- out_ready  in  1  consumer takes the result.
- acc_out  out  ACC_W  signed saturated group sum.
- sat  out  1  sticky: saturation occurred at any point in the group.
- terms  out  CNT_W  number of terms accepted in the group.
- len_err  out  1  group was closed by counter limit, not by `last`.

## Operation
- Two states: ACCUM and DONE.
- ACCUM:
  - `prod_ready` = 1, `out_valid` = 0.
  - Accept = `prod_valid & prod_ready`.
  - On accept: acc <= sat(acc + sext(product)) and terms <= terms + 1.
  - sat |= 1 if the sum leaves [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Clamp to the nearer limit. Saturation is per add: later terms start from the clamped value.
- Transition ACCUM -> DONE on an accept with `last` = 1, or on an accept that makes terms = 2^CNT_W-1. In the second case `len_err` <= 1, unless `last` is also 1.
- DONE:
  - `prod_ready` = 0, `out_valid` = 1.
  - Outputs hold steady until `out_valid & out_ready`.
  - On that handshake: acc, terms, sat and len_err clear to 0 and the state returns to ACCUM.
- `product` and `last` are ignored when no accept occurs.
- A single-term group is legal: `last` on the first accept.
- `prod_valid` may toggle freely; there is no requirement to hold it.

## Timing
- Reset values (state while `rst` = 1 at a clock edge):
  - state = ACCUM; acc_out = 0, terms = 0, sat = 0, len_err = 0, out_valid = 0.
  - `prod_ready` is forced to 0 while `rst` is high.
  - `prod_ready` = 1 in the first cycle after `rst` falls.
- Accumulation latency is 1 cycle: a product accepted at edge k is reflected in acc at edge k.
- Result latency: `out_valid` rises in the cycle after the edge that accepted `last`.
- Minimum group period is N+1 cycles for N terms with `out_ready` held high. DONE always costs one bubble cycle.
- `out_ready` high in the same cycle `out_valid` rises completes the handshake at the next edge.
- `rst` mid-group or in DONE discards the partial or pending result and gives no `out_valid`.
- `rst` wins over a simultaneous accept or handshake.
- All outputs are registered or decoded from state only. There is no combinational path from `prod_valid` or `out_ready` to any output.

## Structure
- Package `product_acc_pkg` holds:
  - the state enum (ACCUM, DONE);
  - the product width constant PROD_W = 16;
  - the ACC_W limit constants helper for sat_max and sat_min.
- One sub-module, `sat_add`:
  - combinational signed adder, parameter ACC_W;
  - inputs acc[ACC_W-1:0] and sign-extended addend;
  - outputs the clamped sum and an overflow bit.
- The top holds the FSM, counter and registers: roughly 150-200 lines in total.

## Test plan
- Reset mid-group:
  - stimulus: accept 0x3F01, 0x3F01, assert `rst` 1 cycle, then a group of a single 0x0001 with `last`.
  - required response: no result for the first group; acc_out = 0x000001, terms = 1.
- Three-term group with `out_ready` = 1:
  - stimulus: products 0x3F01 (127*127), 0x4000 (-128*-128), 0xC000 (-128*128, `last`).
  - required response: acc_out = 0x003F01, terms = 3, sat = 0, `out_valid` exactly 1 cycle, group period 4 cycles.
- Backpressure:
  - stimulus: group 0x0055, 0x00AA with `last`, and `out_ready` = 0 for 5 cycles.
  - required response: acc_out = 0x0000FF held stable, `prod_ready` = 0 throughout, `prod_valid` ignored; after the handshake `prod_ready` = 1 next cycle.
- Saturation with ACC_W = 18:
  - stimulus: nine 0x4000 terms, then 0xC000 with `last`.
  - required response: after the 8th term acc = 0x1FFFF (clamped) with sat set; final acc_out = 0x1FFFF - 0x4000 = 0x1BFFF, sat = 1.
- Negative clamp with ACC_W = 18: nine 0x8001 terms with `last` -> acc_out = 0x20000, sat = 1.
- Counter limit with CNT_W = 3:
  - stimulus: 7 terms of 0x0001 with no `last`.
  - required response: DONE after the 7th accept, terms = 7, acc_out = 7, len_err = 1.
